// File: rtl/memory_access_controller_pkg.sv
// Purpose : shared FSM encodings and default sizing for the memory access controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: 3-bit state encoding MAC_IDLE..MAC_VRELEASE, default strobe
// width and Memory word-index width.
package memory_access_controller_pkg;

    localparam int MAC_DEFAULT_STROBE_CYCLES = 1;
    localparam int MAC_MEM_IDX_BITS          = 12;

    typedef enum logic [2:0] {
        MAC_IDLE     = 3'd0,
        MAC_SETUP    = 3'd1,
        MAC_STROBE   = 3'd2,
        MAC_RELEASE  = 3'd3,
        MAC_RESP     = 3'd4,
        MAC_VSTROBE  = 3'd5,
        MAC_VRELEASE = 3'd6
    } mac_state_e;

endpackage

// File: rtl/memory_access_controller_if.sv
// Purpose : request/response and Memory-side signal bundle of the controller.
// Latency : n/a (wires only).
// Backpressure: req_valid/req_ready on the request side; response has none.
//
// Modports: slave  = the controller (consumes requests, drives Memory).
//           master = datapath plus Memory (issues requests, supplies mem_dout).
interface memory_access_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_error, resp_rdata, busy,
               mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_error, resp_rdata, busy,
               mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/memory_access_controller_mac_strobe_timer.sv
// Purpose : loadable 4-bit down-counter timing the width of a Memory strobe.
// Latency : load takes effect at the next posedge; done is a decode of the count.
// Backpressure: none.
//
// Ports: clock, reset (async active-low), load/load_val, en (decrement), done (count==0).
module mac_strobe_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 4'd0);

endmodule

// File: rtl/memory_access_controller.sv
// Purpose : turns single-word load/store requests into a setup/strobe/release Memory sequence.
// Latency : response 2+STROBE_CYCLES posedges after accept (0 for rejected addresses).
// Backpressure: req_ready only in IDLE; response is a one-cycle pulse with no backpressure.
//
// Ports: clock, reset (async active-low), bus (memory_access_controller_if.slave).
// Optional feature: MEM_READBACK_VERIFY_EN adds a read-back strobe after every
// successful store and flags a data mismatch as resp_error.
module memory_access_controller
    import memory_access_controller_pkg::*;
#(
    parameter int STROBE_CYCLES = MAC_DEFAULT_STROBE_CYCLES,
    parameter int MEM_IDX_BITS  = MAC_MEM_IDX_BITS
) (
    input  logic                        clock,
    input  logic                        reset,
    memory_access_controller_if.slave   bus
);

    localparam int         ADDR_HI_LSB = MEM_IDX_BITS + 2;
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    mac_state_e  state_q, state_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        timer_load;
    logic        timer_en;
    logic        timer_done;
    logic        addr_bad;

    mac_strobe_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (STROBE_LOAD),
        .en       (timer_en),
        .done     (timer_done)
    );

    // Misaligned or beyond the Memory word space: rejected without any strobe.
    assign addr_bad = (bus.req_addr[1:0] != 2'b00) ||
                      ((bus.req_addr >> ADDR_HI_LSB) != 32'd0);

    assign timer_en = (state_q == MAC_STROBE) || (state_q == MAC_VSTROBE);

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_rdata_d = resp_rdata_q;
        timer_load   = 1'b0;

        case (state_q)
            MAC_IDLE: begin
                if (bus.req_valid) begin
                    wr_d = bus.req_write;
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = MAC_RESP;
                        if (!bus.req_write) begin
                            resp_rdata_d = 32'd0;
                        end
                    end else begin
                        err_d      = 1'b0;
                        state_d    = MAC_SETUP;
                        // Only place addr/din move, so they are settled a full
                        // cycle before any strobe rises.
                        mem_addr_d = {2'b00, bus.req_addr[31:2]};
                        if (bus.req_write) begin
                            mem_din_d = bus.req_wdata;
                        end
                    end
                end
            end
            MAC_SETUP: begin
                state_d    = MAC_STROBE;
                timer_load = 1'b1;
            end
            MAC_STROBE: begin
                if (timer_done) begin
                    state_d = MAC_RELEASE;
                    if (!wr_q) begin
                        resp_rdata_d = bus.mem_dout;
                    end
                end
            end
            MAC_RELEASE: begin
`ifdef MEM_READBACK_VERIFY_EN
                if (wr_q) begin
                    state_d    = MAC_VSTROBE;
                    timer_load = 1'b1;
                end else begin
                    state_d = MAC_RESP;
                end
`else
                state_d = MAC_RESP;
`endif
            end
`ifdef MEM_READBACK_VERIFY_EN
            MAC_VSTROBE: begin
                if (timer_done) begin
                    state_d = MAC_VRELEASE;
                    // mem_din_q still holds the store data being verified.
                    err_d   = (bus.mem_dout != mem_din_q);
                end
            end
            MAC_VRELEASE: begin
                state_d = MAC_RESP;
            end
`endif
            MAC_RESP: begin
                state_d = MAC_IDLE;
            end
            default: begin
                state_d = MAC_IDLE;
            end
        endcase

        // Strobes and response are decoded from the next state and registered,
        // so each output is a clean flop edge and ren/wen are mutually exclusive.
        mem_wen_d = (state_d == MAC_STROBE) && wr_q;
        mem_ren_d = (state_d == MAC_STROBE) && !wr_q;
`ifdef MEM_READBACK_VERIFY_EN
        if (state_d == MAC_VSTROBE) begin
            mem_ren_d = 1'b1;
        end
`endif
        resp_valid_d = (state_d == MAC_RESP);
        resp_error_d = (state_d == MAC_RESP) && err_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= MAC_IDLE;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            mem_ren_q    <= mem_ren_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == MAC_IDLE);
    assign bus.busy       = (state_q != MAC_IDLE);
    assign bus.mem_ren    = mem_ren_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule
